multi_pulse_generator: RTL and testbench

MULTI_PULSE_GENERATOR -- requirements
Module: multi_pulse_generator

---
 rtl/multi_pulse_pkg.sv | 20 ++
 rtl/pulse_channel.sv | 77 +++++++
 rtl/multi_pulse_generator.sv | 44 ++++
 tb/tb_multi_pulse_generator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_pulse_pkg.sv
// Shared encodings for the multi-channel pulse generator: channel FSM states,
// channel modes and the channel-select width helper.
package multi_pulse_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    ModePeriodic = 1'b0,
    ModeOneShot  = 1'b1
  } mode_e;

  // Select field is at least one bit wide, even for a single channel.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: period/mode registers, IDLE/RUN FSM and the counter that
// emits a single-cycle pulse every period+1 counted edges.
module pulse_channel
  import multi_pulse_pkg::*;
#(
  parameter int unsigned CNT_W = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_period,
  input  mode_e            cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic             pulse,
  output logic             active
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pulse_q, pulse_d;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;

    if (cfg_we) begin
      period_d = cfg_period;
      mode_d   = cfg_mode;
    end

    // Stop beats start; a config write to a running channel restarts it.
    if (stop) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (start || (cfg_we && (state_q == StRun))) begin
      state_d = StRun;
      cnt_d   = '0;
    end else if ((state_q == StRun) && ce) begin
      if (cnt_q == period_q) begin
        pulse_d = 1'b1;
        cnt_d   = '0;
        if (mode_q == ModeOneShot) begin
          state_d = StIdle;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mode_q   <= ModePeriodic;
      period_q <= '0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse  = pulse_q;
  assign active = (state_q == StRun);

endmodule

// File: rtl/multi_pulse_generator.sv
// Array of independent pulse channels sharing one config-write port; the top
// only decodes the config target and instantiates the channels.
module multi_pulse_generator
  import multi_pulse_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 30,
  localparam int unsigned CH_W  = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_stop,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] active
);

  // Selects >= NUM_CH match no channel, so such writes are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

    pulse_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .cfg_we     (ch_we),
      .cfg_period (cfg_period),
      .cfg_mode   (mode_e'(cfg_mode)),
      .start      (ch_start[i]),
      .stop       (ch_stop[i]),
      .pulse      (pulse[i]),
      .active     (active[i])
    );
  end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed bench for multi_pulse_generator: a 4-channel instance for timing,
// strobes and reset, plus a 3-channel instance for out-of-range config writes.
module tb_multi_pulse_generator;

  logic        clk = 1'b0;
  logic        rst, ce;
  logic        cfg_we, cfg_mode;
  logic [1:0]  cfg_ch;
  logic [29:0] cfg_period;
  logic [3:0]  ch_start, ch_stop, pulse, active;

  logic        cfg_we3, cfg_mode3;
  logic [1:0]  cfg_ch3;
  logic [7:0]  cfg_period3;
  logic [2:0]  start3, stop3, pulse3, active3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_pulse_generator dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_mode   (cfg_mode),
    .ch_start   (ch_start),
    .ch_stop    (ch_stop),
    .pulse      (pulse),
    .active     (active)
  );

  multi_pulse_generator #(
    .NUM_CH (3),
    .CNT_W  (8)
  ) dut3 (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .cfg_we     (cfg_we3),
    .cfg_ch     (cfg_ch3),
    .cfg_period (cfg_period3),
    .cfg_mode   (cfg_mode3),
    .ch_start   (start3),
    .ch_stop    (stop3),
    .pulse      (pulse3),
    .active     (active3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [29:0] n, input logic mode);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = n; cfg_mode = mode;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start(input logic [3:0] mask);
    ch_start = mask;
    step();
    ch_start = '0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_mode = 1'b0;
    ch_start = '0; ch_stop = '0;
    cfg_we3 = 1'b0; cfg_ch3 = '0; cfg_period3 = '0; cfg_mode3 = 1'b0;
    start3 = '0; stop3 = '0;
    step(); step();
    rst = 1'b0;
    check("reset_pulse", pulse, 4'h0);
    check("reset_active", active, 4'h0);
    step(); step();
    check("idle_no_pulse", pulse, 4'h0);

    // Periodic N=3 on ch0: pulses 4, 8, 12 cycles after start.
    cfg(2'd0, 30'd3, 1'b0);
    start(4'b0001);
    check("per_active", active, 4'b0001);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("per_k%0d", k), pulse, ((k % 4) == 0) ? 4'b0001 : 4'b0000);
    end
    ch_stop = 4'b0001; step(); ch_stop = '0;
    check("stop_active", active, 4'h0);
    check("stop_pulse", pulse, 4'h0);

    // One-shot N=5 on ch1: single pulse at cycle 6, active drops together.
    cfg(2'd1, 30'd5, 1'b1);
    start(4'b0010);
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("os_pulse_k%0d", k), pulse, (k == 6) ? 4'b0010 : 4'b0000);
      check($sformatf("os_active_k%0d", k), active, (k < 6) ? 4'b0010 : 4'b0000);
    end

    // N=0 on ch2: pulse every cycle, then only after edges with ce=1.
    cfg(2'd2, 30'd0, 1'b0);
    start(4'b0100);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("n0_k%0d", k), pulse, 4'b0100);
    end
    for (int k = 0; k < 6; k++) begin
      ce = ((k % 2) == 0);
      step();
      check($sformatf("gate_k%0d", k), pulse, ce ? 4'b0100 : 4'b0000);
    end
    ce = 1'b1;
    ch_stop = 4'b0100; step(); ch_stop = '0;

    // Start+stop together on ch3: stop wins.
    ch_start = 4'b1000; ch_stop = 4'b1000; step(); ch_start = '0; ch_stop = '0;
    check("ss_active", active, 4'h0);
    step();
    check("ss_pulse", pulse, 4'h0);

    // Restart at count 2 of N=4: next pulse 5 cycles after the restart.
    cfg(2'd3, 30'd4, 1'b0);
    start(4'b1000);
    step(); step();
    check("rs_pre", pulse, 4'h0);
    start(4'b1000);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("rs_k%0d", k), pulse, (k == 5) ? 4'b1000 : 4'b0000);
    end

    // Config write while running restarts the count with the new period.
    cfg(2'd3, 30'd2, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("cw_k%0d", k), pulse, (k == 3) ? 4'b1000 : 4'b0000);
    end

    // Config write plus stop: config stored, channel idle.
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 30'd1; cfg_mode = 1'b0; ch_stop = 4'b1000;
    step();
    cfg_we = 1'b0; ch_stop = '0;
    check("cws_active", active, 4'h0);
    start(4'b1000);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("cws_k%0d", k), pulse, ((k % 2) == 0) ? 4'b1000 : 4'b0000);
    end
    ch_stop = 4'b1000; step(); ch_stop = '0;

    // Reset mid-count clears everything, overriding a simultaneous start.
    cfg(2'd0, 30'd20, 1'b0);
    cfg(2'd1, 30'd9, 1'b1);
    start(4'b0011);
    for (int k = 0; k < 7; k++) step();
    check("pre_rst_active", active, 4'b0011);
    rst = 1'b1; ch_start = 4'b0001;
    step();
    rst = 1'b0; ch_start = '0;
    check("rst_pulse", pulse, 4'h0);
    check("rst_active", active, 4'h0);
    step();
    check("rst_no_start", active, 4'h0);
    // Period and mode came back as 0 / periodic: pulse every cycle, stays running.
    start(4'b0011);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("post_rst_pulse_k%0d", k), pulse, 4'b0011);
      check($sformatf("post_rst_active_k%0d", k), active, 4'b0011);
    end
    ch_stop = 4'hF; step(); ch_stop = '0;

    // Three-channel instance: a write to cfg_ch=3 must touch nothing.
    cfg_we3 = 1'b1; cfg_ch3 = 2'd2; cfg_period3 = 8'd3; cfg_mode3 = 1'b0;
    step();
    cfg_ch3 = 2'd3; cfg_period3 = 8'd7; cfg_mode3 = 1'b1;
    step();
    cfg_we3 = 1'b0;
    start3 = 3'b111; step(); start3 = '0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("oor_pulse_k%0d", k), pulse3, (k == 4) ? 3'b111 : 3'b011);
      check($sformatf("oor_active_k%0d", k), active3, 3'b111);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
